// File: rtl/pool_pkg.sv
// Shared types and default sizing for the pooling-window controller.
package pool_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_WIN    = 4;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CAPTURE,
    ST_OUT,
    ST_DONE
  } pool_state_e;

endpackage

// File: rtl/pool_ctrl.sv
// Sequences conv beats into pooling windows, captures the pooled vector
// from the external datapath and hands it downstream with a valid/ready handshake.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WIN    = DEF_WIN,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      cfg_windows,
  input  logic                  conv_valid,
  output logic                  conv_ready,
  output logic                  pool_en,
  input  logic [WIN*DATA_W-1:0] pooled_in,
  output logic [WIN*DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BEAT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned VEC_W  = WIN * DATA_W;

  pool_state_e       r_state;
  pool_state_e       w_next;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_win;
  logic [CNT_W-1:0]  r_cfg;
  logic [VEC_W-1:0]  r_out_data;
  logic              r_out_valid;
  logic              w_last_beat;
  logic              w_last_win;

  assign w_last_beat = (r_beat == BEAT_W'(WIN - 1));
  assign w_last_win  = (CNT_W'(r_win + 1'b1) == r_cfg);
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded strobes; abort pre-empts every non-idle action.
  always_comb begin
    w_next     = r_state;
    conv_ready = 1'b0;
    pool_en    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (cfg_windows == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        conv_ready = 1'b1;
        if (abort) begin
          w_next = ST_IDLE;
        end else if (conv_valid && w_last_beat) begin
          pool_en = 1'b1;
          w_next  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: w_next = abort ? ST_IDLE : ST_OUT;
      ST_OUT: begin
        if (abort)          w_next = ST_IDLE;
        else if (out_ready) w_next = w_last_win ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        done   = ~abort;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counters, latched configuration and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat      <= '0;
      r_win       <= '0;
      r_cfg       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_cfg  <= cfg_windows;
        r_beat <= '0;
        r_win  <= '0;
      end
    end else if (abort) begin
      r_beat      <= '0;
      r_win       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (conv_valid) r_beat <= w_last_beat ? '0 : BEAT_W'(r_beat + 1'b1);
        end
        ST_CAPTURE: begin
          r_out_data  <= pooled_in;
          r_out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_win       <= CNT_W'(r_win + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Randomized and directed checks of pool_ctrl against a frame-level reference model.
module tb_pool_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WIN    = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned VEC_W  = WIN * DATA_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_windows;
  logic             conv_valid;
  logic             conv_ready;
  logic             pool_en;
  logic [VEC_W-1:0] pooled_in;
  logic [VEC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  pool_ctrl #(.DATA_W(DATA_W), .WIN(WIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_windows(cfg_windows), .conv_valid(conv_valid), .conv_ready(conv_ready),
    .pool_en(pool_en), .pooled_in(pooled_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: progress counted in beats and windows.
  bit               m_busy;
  bit               m_cap;
  bit               m_hold;
  bit               m_fin;
  int               m_cfg;
  int               m_beats;
  int               m_wins;
  logic [VEC_W-1:0] m_data;

  int n_pool, n_done, n_hs, n_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_pool = 0; n_done = 0; n_hs = 0; n_busy = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_cap = 0; m_hold = 0; m_fin = 0;
    m_cfg = 0; m_beats = 0; m_wins = 0; m_data = '0;
  endtask

  task automatic cycle(input bit st, input bit ab, input int cfg, input bit cv, input bit rdy);
    bit collecting;
    @(posedge clk); #1;
    check("out_valid", 64'(out_valid), 64'(m_hold));
    check("out_data", 64'(out_data), 64'(m_data));
    start = st; abort = ab; cfg_windows = CNT_W'(cfg);
    conv_valid = cv; out_ready = rdy; pooled_in = VEC_W'($urandom);
    #1;
    collecting = m_busy && !m_cap && !m_hold && !m_fin;
    check("conv_ready", 64'(conv_ready), 64'(collecting));
    check("pool_en", 64'(pool_en), 64'(collecting && cv && !ab && (m_beats == WIN - 1)));
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_fin && !ab));
    n_pool += int'(pool_en);
    n_done += int'(done);
    n_hs   += int'(out_valid && out_ready);
    n_busy += int'(busy);
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_cfg = cfg; m_beats = 0; m_wins = 0; m_fin = (cfg == 0);
      end
    end else if (ab) begin
      m_busy = 0; m_cap = 0; m_hold = 0; m_fin = 0; m_beats = 0; m_wins = 0;
    end else if (m_fin) begin
      m_fin = 0; m_busy = 0;
    end else if (m_cap) begin
      m_cap = 0; m_hold = 1; m_data = pooled_in;
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 0; m_wins++;
        if (m_wins == m_cfg) m_fin = 1;
      end
    end else if (cv) begin
      m_beats++;
      if (m_beats == WIN) begin
        m_beats = 0; m_cap = 1;
      end
    end
  endtask

  task automatic mid_reset();
    @(posedge clk); #2;
    start = 0; abort = 0; conv_valid = 0; out_ready = 0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_conv_ready", 64'(conv_ready), 64'(0));
    check("rst_pool_en", 64'(pool_en), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    model_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; cfg_windows = '0;
    conv_valid = 0; out_ready = 0; pooled_in = '0;
    model_reset();
    #12;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    #10 rst_n = 1'b1;

    // One window, back-to-back beats.
    clear_stats();
    cycle(1, 0, 1, 0, 0);
    repeat (4) cycle(0, 0, 1, 1, 1);
    repeat (5) cycle(0, 0, 1, 0, 1);
    check("w1_pool_cnt", 64'(n_pool), 64'(1));
    check("w1_done_cnt", 64'(n_done), 64'(1));
    check("w1_hs_cnt", 64'(n_hs), 64'(1));

    // Two windows, continuous valid and ready.
    clear_stats();
    cycle(1, 0, 2, 1, 1);
    repeat (17) cycle(0, 0, 2, 1, 1);
    check("w2_pool_cnt", 64'(n_pool), 64'(2));
    check("w2_done_cnt", 64'(n_done), 64'(1));
    check("w2_hs_cnt", 64'(n_hs), 64'(2));

    // Backpressure in OUT for five cycles.
    clear_stats();
    cycle(1, 0, 1, 0, 0);
    repeat (4) cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    n_pool = 0;
    repeat (5) cycle(1, 0, 7, 1, 0);
    check("bp_pool_cnt", 64'(n_pool), 64'(0));
    check("bp_hs_cnt", 64'(n_hs), 64'(0));
    repeat (4) cycle(0, 0, 1, 0, 1);
    check("bp_done_cnt", 64'(n_done), 64'(1));

    // Zero-window frame.
    clear_stats();
    cycle(1, 0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);
    check("w0_busy_cnt", 64'(n_busy), 64'(1));
    check("w0_done_cnt", 64'(n_done), 64'(1));
    check("w0_pool_cnt", 64'(n_pool), 64'(0));

    // Reset after two beats, then a fresh frame.
    clear_stats();
    cycle(1, 0, 3, 0, 0);
    repeat (2) cycle(0, 0, 3, 1, 0);
    mid_reset();
    check("rs_done_cnt", 64'(n_done), 64'(0));
    clear_stats();
    cycle(1, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 1, 1, 0);
    check("rs_pool_early", 64'(n_pool), 64'(0));
    cycle(0, 0, 1, 1, 0);
    check("rs_pool_cnt", 64'(n_pool), 64'(1));
    repeat (5) cycle(0, 0, 1, 0, 1);

    // Abort during CAPTURE, start while busy ignored.
    clear_stats();
    cycle(1, 0, 2, 0, 0);
    repeat (4) cycle(1, 0, 0, 1, 1);
    cycle(1, 1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    check("ab_done_cnt", 64'(n_done), 64'(0));
    check("ab_hs_cnt", 64'(n_hs), 64'(0));

    // Randomized traffic with occasional abort and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) mid_reset();
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
            int'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
